// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D scan sequencer: FSM states,
// sample width, default channel list and the converter command-word builder.
package a2d_pkg;

  typedef enum logic [2:0] {IDLE, CMD, DEAD, RD, ACC} state_t;

  localparam int SMPL_W = 12;

  // Slot 0 is the least-significant 3-bit field.
  localparam logic [11:0] DEF_CH_LIST = {3'd6, 3'd5, 3'd4, 3'd0};

  function automatic logic [15:0] cmd_word(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/SPI_mnrch.sv
// 16-bit SPI monarch: SCLK = clk/16, idles high; MOSI changes on SCLK fall,
// MISO is captured just before SCLK rises. One-cycle done pulse per transfer.
module SPI_mnrch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] wt_data,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  logic [3:0]  r_div;
  logic [3:0]  r_bits;
  logic        r_active;
  logic [15:0] r_shft;
  logic        r_smpl;
  logic        r_done;
  logic        r_ss_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div    <= 4'd0;
      r_bits   <= 4'd0;
      r_active <= 1'b0;
      r_shft   <= 16'h0000;
      r_smpl   <= 1'b0;
      r_done   <= 1'b0;
      r_ss_n   <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (wrt && !r_active) begin
        r_active <= 1'b1;
        r_ss_n   <= 1'b0;
        r_div    <= 4'd0;
        r_bits   <= 4'd0;
        r_shft   <= wt_data;
      end else if (r_active) begin
        r_div <= r_div + 4'd1;
        if (r_div == 4'd7) r_smpl <= MISO;
        // The 16th fall is suppressed: SCLK simply returns to its idle level.
        if (r_div == 4'd15) begin
          r_shft <= {r_shft[14:0], r_smpl};
          r_bits <= r_bits + 4'd1;
          if (r_bits == 4'd15) begin
            r_active <= 1'b0;
            r_ss_n   <= 1'b1;
            r_done   <= 1'b1;
          end
        end
      end
    end
  end

  assign done    = r_done;
  assign rd_data = r_shft;
  assign SS_n    = r_ss_n;
  assign SCLK    = r_active ? r_div[3] : 1'b1;
  assign MOSI    = r_active & r_shft[15];

endmodule

// File: rtl/a2d_scan_seq.sv
// Round-robin A2D scan sequencer: command + read SPI transfer per sample,
// optional power-of-two averaging, one 12-bit result register per slot.
module a2d_scan_seq
  import a2d_pkg::*;
#(
  parameter int                  NUM_CH   = 4,
  parameter logic [3*NUM_CH-1:0] CH_LIST  = DEF_CH_LIST,
  parameter int                  AVG_LOG2 = 0,
  parameter int                  DEAD_CYC = 1,
  localparam int                 IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       nxt,
  input  logic                       auto_en,
  output logic [NUM_CH*SMPL_W-1:0]   res,
  output logic                       res_vld,
  output logic [IDX_W-1:0]           res_idx,
  output logic                       busy,
  output logic                       SS_n,
  output logic                       SCLK,
  output logic                       MOSI,
  input  logic                       MISO
);

  localparam int               ACC_W     = SMPL_W + AVG_LOG2;
  localparam int               SC_W      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SC_W-1:0]  SC_LAST   = SC_W'((1 << AVG_LOG2) - 1);
  localparam logic [3:0]       DEAD_LAST = 4'(DEAD_CYC - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [IDX_W-1:0]    r_slot;
  logic [IDX_W-1:0]    w_slot_next;
  logic [3:0]          r_dead;
  logic [SC_W-1:0]     r_scnt;
  logic [ACC_W-1:0]    r_acc;
  logic [SMPL_W-1:0]   r_res [NUM_CH];
  logic                r_res_vld;
  logic [IDX_W-1:0]    r_res_idx;

  logic                w_wrt;
  logic [15:0]         w_wt_data;
  logic                w_done;
  logic [15:0]         w_rd_data;
  logic [2:0]          w_ch;
  logic                w_more;
  logic                w_unused;

  assign w_ch        = CH_LIST[3*r_slot +: 3];
  assign w_more      = (r_scnt < SC_LAST);
  assign w_slot_next = (r_slot == IDX_W'(NUM_CH - 1)) ? '0 : r_slot + 1'b1;
  assign w_unused    = ^w_rd_data[15:SMPL_W];

  always_comb begin
    w_state_next = r_state;
    w_wrt        = 1'b0;
    w_wt_data    = cmd_word(w_ch);
    case (r_state)
      IDLE: if (nxt | auto_en) begin
        w_wrt        = 1'b1;
        w_state_next = CMD;
      end
      CMD:  if (w_done) w_state_next = DEAD;
      DEAD: if (r_dead == DEAD_LAST) begin
        w_wrt        = 1'b1;
        w_wt_data    = 16'h0000;
        w_state_next = RD;
      end
      RD:   if (w_done) w_state_next = ACC;
      ACC:  if (w_more) begin
        w_wrt        = 1'b1;
        w_state_next = CMD;
      end else begin
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_slot    <= '0;
      r_dead    <= 4'd0;
      r_scnt    <= '0;
      r_acc     <= '0;
      r_res_vld <= 1'b0;
      r_res_idx <= '0;
      for (int i = 0; i < NUM_CH; i++) r_res[i] <= '0;
    end else begin
      r_state   <= w_state_next;
      r_res_vld <= 1'b0;
      r_dead    <= (r_state == DEAD) ? r_dead + 4'd1 : 4'd0;
      if (r_state == RD && w_done)
        r_acc <= r_acc + ACC_W'(w_rd_data[SMPL_W-1:0]);
      if (r_state == ACC) begin
        if (w_more) begin
          r_scnt <= r_scnt + 1'b1;
        end else begin
          // Truncating average: drop the AVG_LOG2 low bits of the sum.
          r_res[r_slot] <= r_acc[AVG_LOG2 +: SMPL_W];
          r_res_vld     <= 1'b1;
          r_res_idx     <= r_slot;
          r_slot        <= w_slot_next;
          r_acc         <= '0;
          r_scnt        <= '0;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_res
    assign res[SMPL_W*gi +: SMPL_W] = r_res[gi];
  end

  assign res_vld = r_res_vld;
  assign res_idx = r_res_idx;
  assign busy    = (r_state != IDLE);

  SPI_mnrch u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (w_wrt),
    .wt_data (w_wt_data),
    .done    (w_done),
    .rd_data (w_rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

endmodule

// File: tb/tb_a2d_scan_seq.sv
// Bench for a2d_scan_seq: DUT A at default parameters, DUT B with 3 slots,
// 4x averaging and 3 dead clocks, each driven by a behavioural converter.
module tb_a2d_scan_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // ---------------- DUT A: defaults ----------------
  logic        a_rst_n = 1'b0, a_nxt = 1'b0, a_auto = 1'b0;
  logic [47:0] a_res;
  logic        a_vld, a_busy, a_ss_n, a_sclk, a_mosi, a_miso;
  logic [1:0]  a_idx;

  a2d_scan_seq u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .nxt(a_nxt), .auto_en(a_auto),
    .res(a_res), .res_vld(a_vld), .res_idx(a_idx), .busy(a_busy),
    .SS_n(a_ss_n), .SCLK(a_sclk), .MOSI(a_mosi), .MISO(a_miso)
  );

  // ---------------- DUT B: 3 slots, averaging ----------------
  logic        b_rst_n = 1'b0, b_nxt = 1'b0, b_auto = 1'b0;
  logic [35:0] b_res;
  logic        b_vld, b_busy, b_ss_n, b_sclk, b_mosi, b_miso;
  logic [1:0]  b_idx;

  a2d_scan_seq #(
    .NUM_CH(3), .CH_LIST({3'd2, 3'd7, 3'd1}), .AVG_LOG2(2), .DEAD_CYC(3)
  ) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .nxt(b_nxt), .auto_en(b_auto),
    .res(b_res), .res_vld(b_vld), .res_idx(b_idx), .busy(b_busy),
    .SS_n(b_ss_n), .SCLK(b_sclk), .MOSI(b_mosi), .MISO(b_miso)
  );

  // ---------------- converter model A: 0x123 + 16*ch + bias ----------------
  logic [15:0] a_tx = 16'h0, a_rx = 16'h0;
  logic        a_phase = 1'b0;
  logic [2:0]  a_ch = 3'd0;
  logic [11:0] a_bias = 12'd0;
  int a_ss_fall = 0, a_ss_rise = 0, a_vld_cnt = 0;

  assign a_miso = a_tx[15];
  always @(negedge a_ss_n) begin
    a_ss_fall++;
    a_tx = a_phase ? {4'h0, 12'h123 + {5'd0, a_ch, 4'h0} + a_bias} : 16'h0000;
  end
  always @(posedge a_sclk) begin
    a_rx = {a_rx[14:0], a_mosi};
    a_tx = {a_tx[14:0], 1'b0};
  end
  always @(posedge a_ss_n or negedge a_rst_n) begin
    if (!a_rst_n) a_phase = 1'b0;
    else begin
      a_ss_rise++;
      if (!a_phase) a_ch = a_rx[13:11];
      a_phase = ~a_phase;
    end
  end
  always @(negedge clk) if (a_vld) a_vld_cnt++;

  // ---------------- converter model B: table then 0x200 + ch ----------------
  logic [15:0] b_tx = 16'h0, b_rx = 16'h0;
  logic        b_phase = 1'b0;
  logic [2:0]  b_ch = 3'd0;
  int b_k = 0, b_ss_fall = 0;

  function automatic logic [11:0] b_sample(input int k, input logic [2:0] ch);
    case (k)
      0: return 12'd100;
      1: return 12'd101;
      2: return 12'd102;
      3: return 12'd104;
      default: return 12'h200 + 12'(ch);
    endcase
  endfunction

  assign b_miso = b_tx[15];
  always @(negedge b_ss_n) begin
    b_ss_fall++;
    if (b_phase) begin
      b_tx = {4'h0, b_sample(b_k, b_ch)};
      b_k++;
    end else b_tx = 16'h0000;
  end
  always @(posedge b_sclk) begin
    b_rx = {b_rx[14:0], b_mosi};
    b_tx = {b_tx[14:0], 1'b0};
  end
  always @(posedge b_ss_n or negedge b_rst_n) begin
    if (!b_rst_n) b_phase = 1'b0;
    else begin
      if (!b_phase) b_ch = b_rx[13:11];
      b_phase = ~b_phase;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out, expected event never seen", name);
  endtask

  task automatic pulse_a(input string name);
    @(negedge clk);
    chk({name, "_busy_pre"}, 64'(a_busy), 64'd0);
    a_nxt = 1'b1;
    @(negedge clk);
    a_nxt = 1'b0;
    chk({name, "_busy_rise"}, 64'(a_busy), 64'd1);
  endtask

  task automatic pulse_b(input string name);
    @(negedge clk);
    b_nxt = 1'b1;
    @(negedge clk);
    b_nxt = 1'b0;
    chk({name, "_busy_rise"}, 64'(b_busy), 64'd1);
  endtask

  task automatic wait_a_vld(input int budget, input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (a_vld) ok = 1'b1;
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_b_vld(input int budget, input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (b_vld) ok = 1'b1;
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_a_ss(input bit rise, input int target, input string name);
    bit hit = 1'b0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(negedge clk);
      if ((rise ? a_ss_rise : a_ss_fall) >= target) hit = 1'b1;
    end
    if (!hit) timeout(name);
  endtask

  typedef struct {
    logic [11:0] bias;
    logic [1:0]  idx;
    logic [47:0] res;
  } vec_t;

  vec_t vecs [5];
  bit   ok;
  int   base, rbase, vbase;

  initial begin
    vecs[0] = '{12'd0, 2'd0, 48'h000_000_000_123};
    vecs[1] = '{12'd0, 2'd1, 48'h000_000_163_123};
    vecs[2] = '{12'd0, 2'd2, 48'h000_173_163_123};
    vecs[3] = '{12'd0, 2'd3, 48'h183_173_163_123};
    vecs[4] = '{12'd1, 2'd0, 48'h183_173_163_124};

    repeat (3) @(negedge clk);
    chk("rst_res", 64'(a_res), 64'd0);
    chk("rst_vld", 64'(a_vld), 64'd0);
    chk("rst_idx", 64'(a_idx), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_ss_n", 64'(a_ss_n), 64'd1);
    chk("rst_sclk", 64'(a_sclk), 64'd1);
    chk("rst_mosi", 64'(a_mosi), 64'd0);
    chk("rst_b_res", 64'(b_res), 64'd0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    // Manual round robin on A; last entry revisits slot 0 with a new value.
    for (int i = 0; i < 5; i++) begin
      a_bias = vecs[i].bias;
      base = a_ss_fall;
      pulse_a($sformatf("man%0d", i));
      wait_a_vld(1500, $sformatf("man%0d_vld", i), ok);
      if (ok) begin
        chk($sformatf("man%0d_idx", i), 64'(a_idx), 64'(vecs[i].idx));
        chk($sformatf("man%0d_res", i), 64'(a_res), 64'(vecs[i].res));
        chk($sformatf("man%0d_busy_fall", i), 64'(a_busy), 64'd0);
        chk($sformatf("man%0d_ss_cnt", i), 64'(a_ss_fall - base), 64'd2);
      end
      $display("man%0d: idx=%0d res=0x%0h", i, a_idx, a_res);
    end

    // Averaging on B: 100+101+102+104 = 407, >>2 = 101.
    base = b_ss_fall;
    pulse_b("avg");
    wait_b_vld(3000, "avg_vld", ok);
    if (ok) begin
      chk("avg_idx", 64'(b_idx), 64'd0);
      chk("avg_res", 64'(b_res[11:0]), 64'd101);
      chk("avg_ss_cnt", 64'(b_ss_fall - base), 64'd8);
    end
    $display("avg: idx=%0d res0=%0d ss=%0d", b_idx, b_res[11:0], b_ss_fall - base);

    // Free-running scan on B from a fresh reset.
    @(negedge clk);
    b_rst_n = 1'b0;
    @(negedge clk);
    b_rst_n = 1'b1;
    b_auto  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int s;
      logic [2:0] ch;
      s  = i % 3;
      ch = (s == 0) ? 3'd1 : (s == 1) ? 3'd7 : 3'd2;
      wait_b_vld(3000, $sformatf("auto%0d_vld", i), ok);
      if (!ok) break;
      chk($sformatf("auto%0d_idx", i), 64'(b_idx), 64'(s));
      chk($sformatf("auto%0d_res", i), 64'(b_res[12*s +: 12]), 64'(12'h200 + 12'(ch)));
      chk($sformatf("auto%0d_cmd_ch", i), 64'(b_ch), 64'(ch));
      chk($sformatf("auto%0d_idle", i), 64'(b_busy), 64'd0);
      if (i == 9) b_auto = 1'b0;
      @(negedge clk);
      chk($sformatf("auto%0d_restart", i), 64'(b_busy), 64'(i < 9));
      $display("auto%0d: idx=%0d res=0x%0h", i, b_idx, b_res[12*s +: 12]);
    end

    // nxt during the read transaction must not queue a second slot.
    base  = a_ss_fall;
    vbase = a_vld_cnt;
    pulse_a("rdnxt");
    wait_a_ss(1'b0, base + 2, "rdnxt_rd_start");
    repeat (20) @(negedge clk);
    a_nxt = 1'b1;
    @(negedge clk);
    a_nxt = 1'b0;
    wait_a_vld(1500, "rdnxt_vld", ok);
    if (ok) begin
      chk("rdnxt_idx", 64'(a_idx), 64'd1);
      chk("rdnxt_res", 64'(a_res), 64'h183_173_164_124);
    end
    repeat (700) @(negedge clk);
    chk("rdnxt_vld_cnt", 64'(a_vld_cnt - vbase), 64'd1);
    chk("rdnxt_ss_cnt", 64'(a_ss_fall - base), 64'd2);
    chk("rdnxt_busy", 64'(a_busy), 64'd0);
    $display("rdnxt: vld=%0d ss=%0d", a_vld_cnt - vbase, a_ss_fall - base);

    // Asynchronous reset during the read of slot 2, between clock edges.
    a_bias = 12'd2;
    base = a_ss_fall;
    pulse_a("arst");
    wait_a_ss(1'b0, base + 2, "arst_rd_start");
    repeat (40) @(negedge clk);
    #2 a_rst_n = 1'b0;
    #1;
    chk("arst_res", 64'(a_res), 64'd0);
    chk("arst_vld", 64'(a_vld), 64'd0);
    chk("arst_idx", 64'(a_idx), 64'd0);
    chk("arst_busy", 64'(a_busy), 64'd0);
    chk("arst_ss_n", 64'(a_ss_n), 64'd1);
    chk("arst_sclk", 64'(a_sclk), 64'd1);
    chk("arst_mosi", 64'(a_mosi), 64'd0);
    @(negedge clk);
    a_rst_n = 1'b1;
    base = a_ss_fall;
    pulse_a("post");
    wait_a_vld(1500, "post_vld", ok);
    if (ok) begin
      chk("post_idx", 64'(a_idx), 64'd0);
      chk("post_res", 64'(a_res), 64'h000_000_000_125);
      chk("post_cmd_ch", 64'(a_ch), 64'd0);
      chk("post_ss_cnt", 64'(a_ss_fall - base), 64'd2);
    end
    $display("post: idx=%0d res=0x%0h", a_idx, a_res);

    // auto_en dropped while slot 1 sits in its dead time.
    base  = a_ss_fall;
    rbase = a_ss_rise;
    @(negedge clk);
    a_auto = 1'b1;
    wait_a_ss(1'b1, rbase + 1, "drop_cmd_end");
    @(negedge clk);
    a_auto = 1'b0;
    wait_a_vld(1500, "drop_vld", ok);
    if (ok) begin
      chk("drop_idx", 64'(a_idx), 64'd1);
      chk("drop_res", 64'(a_res), 64'h000_000_165_125);
    end
    repeat (700) @(negedge clk);
    chk("drop_ss_cnt", 64'(a_ss_fall - base), 64'd2);
    chk("drop_busy", 64'(a_busy), 64'd0);
    $display("drop: idx=%0d ss=%0d", a_idx, a_ss_fall - base);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/a2d_scan_seq.md
# a2d_scan_seq

Parametrised round-robin sequencer for the off-board SPI A2D converter. Walks a configurable list of converter channels and optionally oversamples and averages each one. Publishes one 12-bit result register per channel, plus a valid strobe and channel tag. Sits between the SPI monarch and the consumers of load-cell, steering-pot and battery readings, and replaces the fixed four-channel interface.

## Interface
- NUM_CH, 4, number of scanned channels (1..8)
- CH_LIST, {3'd6,3'd5,3'd4,3'd0}, packed 3-bit converter channel per slot; slot i = CH_LIST[3i+:3]
- AVG_LOG2, 0, log2 of samples averaged per channel (0..3)
- DEAD_CYC, 1, idle clocks between the command and read transactions (1..15)
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- nxt  in  1  single-cycle request for one channel result (manual mode)
- auto_en  in  1  level; when 1, free-running scan with no nxt needed
- res  out  NUM_CH*12  result bank; slot i = res[12i+:12]
- res_vld  out  1  one-cycle pulse when a slot is updated
- res_idx  out  $clog2(NUM_CH) (min 1)  slot updated, valid with res_vld
- busy  out  1  high whenever the state is not IDLE
- SS_n, SCLK, MOSI  out  1 each  SPI to converter
- MISO  in  1  SPI from converter

## Operation
- Each sample is two 16-bit SPI transactions. First is the command {2'b00, CH_LIST slot, 11'h000}. Second is 16'h0000, and its rd_data[11:0] is the sample.
- States and transitions:
  - IDLE → CMD on (nxt | auto_en); wrt is asserted in the same cycle.
  - CMD → DEAD on done.
  - DEAD holds for DEAD_CYC clocks, then → RD with wrt asserted.
  - RD → ACC on done; the sample is added to the accumulator.
  - ACC: if sample count < 2^AVG_LOG2 − 1, increment the count and go to CMD with wrt asserted. Otherwise write the result, clear the accumulator and count, advance the slot, and go to IDLE.
- Accumulator is 12+AVG_LOG2 bits, unsigned, zero-extended samples; cannot overflow.
- Result = acc[AVG_LOG2+:12] (truncating shift, no rounding).
- Slot index increments after each result and wraps from NUM_CH−1 to 0.
- nxt while busy is ignored, not queued.
- Dropping auto_en mid-scan finishes the current slot, then the block stays in IDLE.
- nxt and auto_en together in IDLE start exactly one slot.
- Only the addressed slot of res changes; all other slots hold.

## Timing
- Reset: all res slots 0, res_vld 0, res_idx 0, busy 0, state IDLE, slot 0, accumulator and count 0. SS_n=1, SCLK=1, MOSI=0 (SPI monarch reset values).
- Reset mid-transaction aborts immediately. Partial accumulation is discarded, and slot 0 is the next slot served.
- res updates and res_vld pulses on the clock edge leaving ACC. res_idx is valid in the same cycle as res_vld.
- busy rises the cycle after the start request and falls with the res_vld pulse.
- Per-slot latency = 2^AVG_LOG2 × (2 transactions + DEAD_CYC + 1) clocks beyond SPI time.
- In auto mode, IDLE lasts exactly one clock between slots.

## Structure
- Shared package a2d_pkg holds:
  - the state enum (IDLE, CMD, DEAD, RD, ACC)
  - the 12-bit sample width constant
  - the command-word builder function
  - the default channel list constant
- One sub-module: the existing SPI_mnrch, instantiated once, 16-bit, unchanged.
- Slot counter, dead-time counter and sample counter are inline registers.

## Test plan
- Default params, converter model returns 12'h123 + 16·channel. Pulse nxt four times. Expect:
  - res_idx sequence 0,1,2,3
  - res = {12'h183, 12'h173, 12'h163, 12'h123}
  - fifth nxt overwrites slot 0 only
- AVG_LOG2=2, model returns 100, 101, 102, 104 for one slot. Expect result 101 (407>>2), and exactly 8 SS_n low periods before res_vld.
- auto_en held for 10 results with NUM_CH=3. Expect:
  - res_idx 0,1,2,0,1,2,0,1,2,0
  - IDLE exactly one clock between slots
  - MOSI command bits match CH_LIST
- nxt pulsed during RD. Expect no extra transaction, exactly one res_vld, and busy low afterwards.
- rst_n asserted during the second transaction of slot 2. Expect:
  - outputs cleared asynchronously
  - SS_n high
  - the next nxt converts slot 0
- auto_en dropped during DEAD of slot 1. Expect slot 1 to complete, res_vld with res_idx=1, then no further SS_n activity.
